buzzer_controller: RTL and testbench
====================================

BUZZER_CONTROLLER -- requirements
Module: buzzer_controller

Interface
REQ-001 The block SHALL have parameter ANS_W, default 16, meaning the width of the answer-time limit and timer.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  host pulse that arms a round; honoured only in IDLE.
REQ-005 clear  input  1  host pulse that aborts or ends a round and returns the block to IDLE.
REQ-006 buzz_in  input  10  raw, asynchronous player buttons; bit i is player i+1.
REQ-007 ans_limit  input  ANS_W  answer window in clk cycles; 0 disables the timeout.
REQ-008 winner  output  4  winning player code 1..10; 0 means no winner.
REQ-009 winner_valid  output  1  high while a winner is latched.
REQ-010 timeout  output  1  high once the answer window has expired.
REQ-011 armed  output  1  high while the state is ARMED.
REQ-012 false_start  output  10  players disqualified for the current round.

Function
REQ-013 buzz_in SHALL pass through a 2-flop synchronizer per bit, giving buzz_s; no other logic SHALL use raw buzz_in.
REQ-014 The block SHALL have a 4-state FSM: IDLE, ARMED, LOCKED, EXPIRED.
REQ-015 Player code SHALL follow the team priority-encoder convention:
- lowest set bit index i wins;
- code = i+1;
- no bit set gives 0.
REQ-016 IDLE, on start=1:
- false_start <= buzz_s;
- next state ARMED.
REQ-017 ARMED, eligible = buzz_s & ~false_start.
- If eligible != 0: winner <= code(eligible), winner_valid <= 1, timer <= 0, next state LOCKED.
- Otherwise stay ARMED.
REQ-018 Simultaneous eligible presses in one cycle SHALL resolve to the lowest index; later presses SHALL be ignored until the next round.
REQ-019 LOCKED, timer SHALL increment each cycle.
- With ans_limit != 0, when timer == ans_limit-1: timeout <= 1, next state EXPIRED.
- timeout therefore rises exactly ans_limit cycles after winner_valid rises.
- With ans_limit == 0: stay LOCKED until clear; timer SHALL saturate at all-ones and not wrap.
REQ-020 ans_limit SHALL be sampled continuously in LOCKED; the host SHALL keep it stable during a round (otherwise behaviour is undefined apart from no wrap).
REQ-021 EXPIRED SHALL hold winner, winner_valid=1 and timeout=1 until clear.
REQ-022 clear=1 in any state, next edge:
- state IDLE;
- winner=0, winner_valid=0, timeout=0, false_start=0, timer=0.
REQ-023 clear SHALL take priority over start and over any buzz in the same cycle.
REQ-024 start outside IDLE SHALL be ignored and SHALL NOT alter false_start.
REQ-025 armed SHALL be a registered decode of state==ARMED.
REQ-026 All outputs SHALL be registered; none SHALL be combinational from inputs.
REQ-027 Latency: a press held stable across the edges SHALL produce winner_valid high after the 3rd rising clk edge following its setup (2 synchronizer stages + 1 latch stage).
REQ-028 A false-started player SHALL remain masked for the whole round even after releasing and pressing again.
REQ-029 A winner's release SHALL NOT clear winner; only clear or rst SHALL clear it.

Reset
REQ-030 rst SHALL asynchronously force:
- state=IDLE;
- winner=0, winner_valid=0, timeout=0, armed=0, false_start=0;
- timer=0;
- both synchronizer stages=0.
REQ-031 rst asserted mid-round, including in LOCKED or EXPIRED, SHALL discard the round with no output glitch beyond the reset values.
REQ-032 After rst deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-033 Test: start, then buzz_in=10'b0000100000 held. Required: winner=6 and winner_valid=1 on the 3rd edge after the press; armed=0 on the same edge.
REQ-034 Test: armed, then buzz_in=10'b1000001000 applied in one cycle. Required: winner=4; a later release of bit 3 leaves winner=4.
REQ-035 Test: buzz_in bit 2 held while start pulses, then bit 7 pressed. Required: false_start=10'b0000000100, bit 2 ignored, winner=8.
REQ-036 Test: ans_limit=5, a winner is latched. Required: timeout rises exactly 5 cycles after winner_valid; state EXPIRED until clear; ans_limit=0 never times out over 70000 cycles.
REQ-037 Test: clear and start in the same cycle while LOCKED. Required: IDLE, all outputs 0; a later start re-arms.
REQ-038 Test: rst asserted asynchronously while EXPIRED, between clock edges. Required: all outputs 0 immediately; a subsequent press without start produces no winner.

Source files
------------

// File: rtl/buzzer_controller.sv
// Quiz-show buzzer controller: synchronizes ten player buttons, arms a round
// on start, latches the first eligible player (lowest index wins ties), then
// optionally times the answer window. Players already pressing when the round
// is armed are disqualified for that round.
module buzzer_controller #(
  parameter int ANS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [9:0]       buzz_in,
  input  logic [ANS_W-1:0] ans_limit,
  output logic [3:0]       winner,
  output logic             winner_valid,
  output logic             timeout,
  output logic             armed,
  output logic [9:0]       false_start
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_LOCKED,
    S_EXPIRED
  } state_t;

  state_t           state, state_next;
  logic [9:0]       buzz_meta, buzz_s;
  logic [ANS_W-1:0] timer, timer_next;
  logic [3:0]       winner_next;
  logic             winner_valid_next;
  logic             timeout_next;
  logic [9:0]       false_start_next;
  logic [9:0]       eligible;

  // Player code: lowest set bit index i gives i+1; no bit set gives 0.
  function automatic logic [3:0] player_code(input logic [9:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (v[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

  // Two-flop synchronizer per button bit; only buzz_s is used downstream.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes the stages chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzz_meta <= '0;
      buzz_s    <= '0;
    end else begin
      buzz_meta <= buzz_in;
      buzz_s    <= buzz_meta;
    end
  end

  assign eligible = buzz_s & ~false_start;

  // Next-state and next-output decode for the round FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next        = state;
    winner_next       = winner;
    winner_valid_next = winner_valid;
    timeout_next      = timeout;
    false_start_next  = false_start;
    timer_next        = timer;

    if (clear) begin
      state_next        = S_IDLE;
      winner_next       = 4'd0;
      winner_valid_next = 1'b0;
      timeout_next      = 1'b0;
      false_start_next  = '0;
      timer_next        = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            false_start_next = buzz_s;
            state_next       = S_ARMED;
          end
        end
        S_ARMED: begin
          if (eligible != '0) begin
            winner_next       = player_code(eligible);
            winner_valid_next = 1'b1;
            timer_next        = '0;
            state_next        = S_LOCKED;
          end
        end
        S_LOCKED: begin
          // Saturate rather than wrap so a disabled timeout never fires.
          if (timer != '1) timer_next = timer + ANS_W'(1);
          if (ans_limit != '0 && timer == ans_limit - ANS_W'(1)) begin
            timeout_next = 1'b1;
            state_next   = S_EXPIRED;
          end
        end
        S_EXPIRED: begin
          state_next = S_EXPIRED;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State and registered outputs; armed is decoded from the next state so it
  // lines up exactly with state==ARMED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      winner       <= 4'd0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      armed        <= 1'b0;
      false_start  <= '0;
      timer        <= '0;
    end else begin
      state        <= state_next;
      winner       <= winner_next;
      winner_valid <= winner_valid_next;
      timeout      <= timeout_next;
      armed        <= (state_next == S_ARMED);
      false_start  <= false_start_next;
      timer        <= timer_next;
    end
  end

endmodule

// File: tb/tb_buzzer_controller.sv
// Self-checking bench for buzzer_controller: directed scenarios plus random
// stimulus, compared each cycle against a round-level behavioural model.
module tb_buzzer_controller;

  localparam int ANS_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             clear;
  logic [9:0]       buzz_in;
  logic [ANS_W-1:0] ans_limit;
  logic [3:0]       winner;
  logic             winner_valid;
  logic             timeout;
  logic             armed;
  logic [9:0]       false_start;

  int n_checks = 0;
  int n_errors = 0;

  // Round-level model: whether a round is open, who won, how long ago.
  bit         m_in_round;
  bit         m_expired;
  int         m_win;
  int         m_age;
  logic [9:0] m_mask;
  logic [9:0] hist [2];

  buzzer_controller #(.ANS_W(ANS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clear        (clear),
    .buzz_in      (buzz_in),
    .ans_limit    (ans_limit),
    .winner       (winner),
    .winner_valid (winner_valid),
    .timeout      (timeout),
    .armed        (armed),
    .false_start  (false_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_round = 1'b0;
    m_expired  = 1'b0;
    m_win      = 0;
    m_age      = 0;
    m_mask     = '0;
    hist[0]    = '0;
    hist[1]    = '0;
  endtask

  // One clock edge of the model; button samples reach the decision logic
  // two edges after they are presented.
  task automatic model_edge();
    logic [9:0] bs;
    logic [9:0] elig;
    bs      = hist[1];
    hist[1] = hist[0];
    hist[0] = buzz_in;
    if (clear) begin
      m_in_round = 1'b0;
      m_expired  = 1'b0;
      m_win      = 0;
      m_age      = 0;
      m_mask     = '0;
    end else if (!m_in_round) begin
      if (start) begin
        m_in_round = 1'b1;
        m_mask     = bs;
      end
    end else if (m_win == 0) begin
      elig = bs & ~m_mask;
      if (elig != '0) begin
        for (int i = 9; i >= 0; i--) if (elig[i]) m_win = i + 1;
        m_age = 0;
      end
    end else if (!m_expired) begin
      m_age++;
      if (ans_limit != '0 && m_age >= int'(ans_limit)) m_expired = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("winner",       32'(winner),       32'(m_win));
    check("winner_valid", 32'(winner_valid), 32'(m_win != 0));
    check("timeout",      32'(timeout),      32'(m_expired));
    check("armed",        32'(armed),        32'(m_in_round && m_win == 0));
    check("false_start",  32'(false_start),  32'(m_mask));
  endtask

  task automatic step(input bit chk = 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    if (chk) compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int n_to_valid;
    int n_to_timeout;

    rst = 1'b1; start = 1'b0; clear = 1'b0; buzz_in = '0; ans_limit = '0;
    model_reset();
    #12 rst = 1'b0;

    // Reset state and idling without start.
    step();
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_armed",  32'(armed),  32'd0);
    steps(3);

    // Single press, latency of three edges, armed drops with the latch.
    pulse_start();
    steps(2);
    check("armed_on", 32'(armed), 32'd1);
    buzz_in = 10'b0000100000;
    step();
    check("lat_e1", 32'(winner_valid), 32'd0);
    step();
    check("lat_e2", 32'(winner_valid), 32'd0);
    step();
    check("lat_winner", 32'(winner), 32'd6);
    check("lat_valid",  32'(winner_valid), 32'd1);
    check("lat_armed",  32'(armed), 32'd0);
    buzz_in = '0;
    do_clear();

    // Simultaneous press resolves to lowest index; release keeps winner.
    pulse_start();
    steps(2);
    buzz_in = 10'b1000001000;
    step();
    buzz_in = 10'b1000000000;
    steps(4);
    check("tie_winner", 32'(winner), 32'd4);
    buzz_in = '0;
    steps(3);
    check("release_winner", 32'(winner), 32'd4);
    do_clear();

    // False start masked for the whole round, even after re-pressing.
    buzz_in = 10'b0000000100;
    steps(3);
    pulse_start();
    check("fs_mask", 32'(false_start), 32'h004);
    steps(3);
    check("fs_ignored", 32'(winner_valid), 32'd0);
    buzz_in = '0;
    steps(3);
    buzz_in = 10'b0000000100;
    steps(3);
    check("fs_repress", 32'(winner_valid), 32'd0);
    buzz_in = 10'b0010000100;
    steps(3);
    check("fs_winner", 32'(winner), 32'd8);
    buzz_in = '0;
    do_clear();

    // Timeout exactly ans_limit cycles after winner_valid.
    ans_limit = 16'd5;
    pulse_start();
    steps(2);
    buzz_in = 10'b0000000001;
    n_to_valid = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (winner_valid) begin n_to_valid = n; break; end
    end
    check("to_valid_seen", 32'(n_to_valid), 32'd3);
    buzz_in = '0;
    n_to_timeout = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (timeout) begin n_to_timeout = n; break; end
    end
    check("to_delay", 32'(n_to_timeout), 32'd5);
    steps(10);
    check("to_hold_timeout", 32'(timeout), 32'd1);
    check("to_hold_winner",  32'(winner),  32'd1);
    do_clear();

    // clear and start together while LOCKED: clear wins, then re-arm.
    ans_limit = '0;
    pulse_start();
    steps(2);
    buzz_in = 10'b1000000000;
    steps(3);
    buzz_in = '0;
    check("cs_locked", 32'(winner), 32'd10);
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    check("cs_winner", 32'(winner), 32'd0);
    check("cs_armed",  32'(armed),  32'd0);
    step();
    pulse_start();
    check("cs_rearm", 32'(armed), 32'd1);
    do_clear();

    // ans_limit=0 never times out, even past timer saturation.
    pulse_start();
    steps(2);
    buzz_in = 10'b0000010000;
    steps(3);
    buzz_in = '0;
    for (int n = 1; n <= 70000; n++) step(n % 5000 == 0);
    check("nolimit_timeout", 32'(timeout), 32'd0);
    check("nolimit_valid",   32'(winner_valid), 32'd1);
    do_clear();

    // Asynchronous reset in EXPIRED, between edges.
    ans_limit = 16'd3;
    pulse_start();
    steps(2);
    buzz_in = 10'b0000000010;
    steps(3);
    buzz_in = '0;
    steps(4);
    check("ar_expired", 32'(timeout), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_winner",  32'(winner),       32'd0);
    check("ar_valid",   32'(winner_valid), 32'd0);
    check("ar_timeout", 32'(timeout),      32'd0);
    check("ar_armed",   32'(armed),        32'd0);
    check("ar_fs",      32'(false_start),  32'd0);
    model_reset();
    #2 rst = 1'b0;
    buzz_in = 10'b0000000001;
    steps(6);
    check("ar_no_winner", 32'(winner_valid), 32'd0);
    buzz_in = '0;
    steps(2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      start = ($urandom_range(7) == 0);
      clear = ($urandom_range(39) == 0);
      if ($urandom_range(3) == 0) begin
        r = $urandom_range(9);
        if (r < 5)      buzz_in = '0;
        else if (r < 8) buzz_in = 10'(1 << $urandom_range(9));
        else            buzz_in = 10'($urandom);
      end
      if (!m_in_round) ans_limit = 16'($urandom_range(6));
      step();
    end
    start = 1'b0; clear = 1'b0; buzz_in = '0;
    steps(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
